vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Video timing and pixel-output stage for the dino game. Upstream of the caravel pins mprj_io[32:30] (pixel, hsync, vsync).
- Generates 800x600@60 timing from the 40 MHz core clock and publishes the current beam coordinate to the game/sprite logic.
- Takes the 1-bit pixel back after a fixed latency and drives registered, mutually aligned pixel/hsync/vsync outputs.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync pulse width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, asserted level of hsync/vsync (1 = positive)
- PIX_LATENCY, 2, clocks from x/y to pixel_in valid; legal range 0..4

Ports:
- clk  in  1  core clock, 40 MHz
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  run timing; 0 = synchronous restart and hold idle
- x  out  11  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- active  out  1  x<H_ACTIVE && y<V_ACTIVE
- pixel_in  in  1  pixel for coordinate issued PIX_LATENCY clocks earlier
- vga_pixel  out  1  registered pixel, forced 0 outside active
- vga_hsync  out  1  registered hsync
- vga_vsync  out  1  registered vsync
- frame_start  out  1  one-clock pulse when x==0 && y==0
- line_start  out  1  one-clock pulse when x==0

Behaviour:
- Totals:
  - H_TOTAL = sum of the four H parameters = 1056.
  - V_TOTAL = sum of the four V parameters = 628.
- Counters:
  - x and y are registered.
  - x increments every clk while running. x wraps H_TOTAL-1 -> 0.
  - y increments on each x wrap. y wraps V_TOTAL-1 -> 0 only when x also wraps.
- Coordinate-phase syncs:
  - hs_raw is true for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. x 840..967.
  - vs_raw is true for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. y 601..604, over whole lines.
- Alignment:
  - active, hs_raw and vs_raw pass through a PIX_LATENCY-deep delay line, so they arrive alongside pixel_in.
  - The output register then samples:
    - vga_pixel = pixel_in & active_d
    - vga_hsync = hs_d ? SYNC_POL : !SYNC_POL
    - vga_vsync = vs_d ? SYNC_POL : !SYNC_POL
- Latency: coordinate (x,y) presented at cycle t appears on the pins at cycle t+PIX_LATENCY+1.
- frame_start and line_start are combinational from the registered counters, in the coordinate phase (not delayed).
- Reset (reset_n=0 at a clk edge):
  - x=0, y=0, delay line cleared to inactive.
  - vga_pixel=0, vga_hsync=vga_vsync=!SYNC_POL.
  - active=1, frame_start=line_start=1 (since x=y=0).
- Reset mid-line or mid-frame: same result, no partial sync pulse is completed. Counting resumes from (0,0) on the first clk with reset_n=1 and enable=1.
- enable=0:
  - Identical to reset for counters, delay line and outputs.
  - active, frame_start and line_start are forced 0.
  - Re-assertion starts a full frame at (0,0).
- pixel_in is ignored (masked) whenever active_d=0. A pixel_in X during blanking must not propagate.

Decomposition:
- Package vga_pkg holds:
  - the 800x600@60 timing localparams and derived H_TOTAL/V_TOTAL;
  - the counter widths (X_W=11, Y_W=10);
  - a typedef for the 3-bit {active,hs,vs} timing word.
- Sub-module vga_delay_line:
  - Parameterised width/depth shift register with synchronous active-low clear.
  - Depth 0 = wire-through.
  - Used for the timing word.

Test Plan:
- Reset: hold reset_n=0 for 5 clks -> vga_hsync=vga_vsync=0, vga_pixel=0, x=0, y=0. After release, x reaches 5 five clocks later.
- Line timing (defaults):
  - vga_hsync rises exactly 840+3 clks after a line_start pulse and stays high 128 clks.
  - line_start pulses are spaced 1056 clks apart.
- Frame timing:
  - frame_start pulses are spaced 663168 clks apart.
  - vga_vsync is high for exactly 4224 consecutive clks, beginning 601*1056+3 clks after frame_start.
- Pixel alignment: drive pixel_in = x[0] of the coordinate from 2 clks earlier (a model of the game pipeline) -> vga_pixel alternates 1/0 across all 800 visible positions of line 0. It is 0 for all 256 blanking clocks, and 0 on lines 600..627.
- Blanking mask: force pixel_in=1 constantly -> vga_pixel high exactly 800 clks per visible line and never during vsync.
- Mid-operation restart:
  - Drop enable at x=500, y=300 for 10 clks -> outputs go idle next clk.
  - After re-enable, frame_start fires immediately and the next hsync begins 843 clks later.
  - Repeat the same check with reset_n instead of enable.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 800x600@60 video sync generator.
package vga_pkg;

    // Default 800x600@60 timing, 40 MHz pixel clock
    localparam int VGA_H_ACTIVE    = 800;
    localparam int VGA_H_FP        = 40;
    localparam int VGA_H_SYNC      = 128;
    localparam int VGA_H_BP        = 88;
    localparam int VGA_V_ACTIVE    = 600;
    localparam int VGA_V_FP        = 1;
    localparam int VGA_V_SYNC      = 4;
    localparam int VGA_V_BP        = 23;
    localparam bit VGA_SYNC_POL    = 1'b1;
    localparam int VGA_PIX_LATENCY = 2;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Beam counter widths (cover 0..1055 and 0..627)
    localparam int X_W = 11;
    localparam int Y_W = 10;

    // Timing word carried alongside the pixel pipeline
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } timing_word_t;

    localparam int TIMING_W = $bits(timing_word_t);

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear.
// DEPTH = 0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_reg [DEPTH];

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    // first stage samples the input word
                    always_ff @(posedge clk) begin
                        if (!clear_n) begin
                            stage_reg[0] <= '0;
                        end else begin
                            stage_reg[0] <= din;
                        end
                    end
                end else begin : g_next
                    // later stages shift the previous stage forward
                    always_ff @(posedge clk) begin
                        if (!clear_n) begin
                            stage_reg[gi] <= '0;
                        end else begin
                            stage_reg[gi] <= stage_reg[gi-1];
                        end
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// Beam counters, coordinate-phase sync decode and the aligned pixel/sync
// output register that feeds the VGA pins.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter bit SYNC_POL    = VGA_SYNC_POL,
    parameter int PIX_LATENCY = VGA_PIX_LATENCY   // legal 0..4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           active,
    input  logic           pixel_in,
    output logic           vga_pixel,
    output logic           vga_hsync,
    output logic           vga_vsync,
    output logic           frame_start,
    output logic           line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_HS_BEG = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] X_HS_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] Y_VS_BEG = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] Y_VS_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    // Reset and disable behave identically for all state
    logic run;
    assign run = reset_n & enable;

    logic [X_W-1:0] x_reg;
    logic [Y_W-1:0] y_reg;

    // Beam counters: x every clock, y on each x wrap
    always_ff @(posedge clk) begin
        if (!run) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (x_reg == X_LAST) begin
            x_reg <= '0;
            y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + Y_W'(1);
        end else begin
            x_reg <= x_reg + X_W'(1);
        end
    end

    // Coordinate-phase decode
    logic active_raw;
    logic hs_raw;
    logic vs_raw;

    assign active_raw = (x_reg < X_ACT) && (y_reg < Y_ACT);
    assign hs_raw     = (x_reg >= X_HS_BEG) && (x_reg < X_HS_END);
    assign vs_raw     = (y_reg >= Y_VS_BEG) && (y_reg < Y_VS_END);

    assign x           = x_reg;
    assign y           = y_reg;
    assign active      = enable & active_raw;
    assign line_start  = enable & (x_reg == '0);
    assign frame_start = line_start & (y_reg == '0);

    // Timing word travels with the game pipeline so it lands next to pixel_in
    timing_word_t tw_now;
    timing_word_t tw_dly;

    assign tw_now = '{active: active, hs: hs_raw, vs: vs_raw};

    vga_delay_line #(
        .WIDTH (TIMING_W),
        .DEPTH (PIX_LATENCY)
    ) u_tw_delay (
        .clk     (clk),
        .clear_n (run),
        .din     (tw_now),
        .dout    (tw_dly)
    );

    logic pixel_reg;
    logic hsync_reg;
    logic vsync_reg;

    // Pin register; AND-masking keeps an undefined pixel_in out of blanking
    always_ff @(posedge clk) begin
        if (!run) begin
            pixel_reg <= 1'b0;
            hsync_reg <= ~SYNC_POL;
            vsync_reg <= ~SYNC_POL;
        end else begin
            pixel_reg <= pixel_in & tw_dly.active;
            hsync_reg <= tw_dly.hs ? SYNC_POL : ~SYNC_POL;
            vsync_reg <= tw_dly.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign vga_pixel = pixel_reg;
    assign vga_hsync = hsync_reg;
    assign vga_vsync = vsync_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a shrunken-timing
// instance (negative syncs, latency 3) so whole frames fit in a short run.
module tb_vga_sync_gen;

    // index 0 = default instance, index 1 = small instance
    localparam int HA  [2] = '{800, 20};
    localparam int HF  [2] = '{40, 4};
    localparam int HS  [2] = '{128, 6};
    localparam int HB  [2] = '{88, 5};
    localparam int VA  [2] = '{600, 10};
    localparam int VF  [2] = '{1, 1};
    localparam int VS  [2] = '{4, 2};
    localparam int VB  [2] = '{23, 3};
    localparam bit POL [2] = '{1'b1, 1'b0};
    localparam int LAT [2] = '{2, 3};

    function automatic int ht(input int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int vt(input int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        pixel_in = 1'b0;
    logic        pixel_in_s = 1'b0;

    logic [10:0] x, x_s;
    logic [9:0]  y, y_s;
    logic        active, active_s;
    logic        vga_pixel, vga_pixel_s;
    logic        vga_hsync, vga_hsync_s;
    logic        vga_vsync, vga_vsync_s;
    logic        frame_start, frame_start_s;
    logic        line_start, line_start_s;

    int total = 0;
    int bad = 0;
    int pix_mode = 0;   // 0 random (X in blanking on small), 1 x[0] pattern, 2 constant 1

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .x           (x),
        .y           (y),
        .active      (active),
        .pixel_in    (pixel_in),
        .vga_pixel   (vga_pixel),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    vga_sync_gen #(
        .H_ACTIVE    (20),
        .H_FP        (4),
        .H_SYNC      (6),
        .H_BP        (5),
        .V_ACTIVE    (10),
        .V_FP        (1),
        .V_SYNC      (2),
        .V_BP        (3),
        .SYNC_POL    (1'b0),
        .PIX_LATENCY (3)
    ) dut_s (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .x           (x_s),
        .y           (y_s),
        .active      (active_s),
        .pixel_in    (pixel_in_s),
        .vga_pixel   (vga_pixel_s),
        .vga_hsync   (vga_hsync_s),
        .vga_vsync   (vga_vsync_s),
        .frame_start (frame_start_s),
        .line_start  (line_start_s)
    );

    // Reference model: linear beam index per instance, a history of indices,
    // and the pin values implied by the coordinate LAT+1 clocks back.
    int   ec = 0;
    int   streak = 0;
    int   idx [2] = '{0, 0};
    int   hist [2][16] = '{default: 0};
    logic exp_pix [2] = '{1'b0, 1'b0};
    logic exp_hs  [2] = '{1'b0, 1'b1};
    logic exp_vs  [2] = '{1'b0, 1'b1};

    always @(posedge clk) begin : model
        int   c, cx, cy;
        bit   run;
        logic pin, act;
        run = (reset_n === 1'b1) && (enable === 1'b1);
        ec = ec + 1;
        streak = run ? streak + 1 : 0;
        for (int i = 0; i < 2; i++) begin
            pin = (i == 0) ? pixel_in : pixel_in_s;
            idx[i] = run ? (idx[i] + 1) % (ht(i) * vt(i)) : 0;
            hist[i][ec % 16] = idx[i];
            if (streak >= LAT[i] + 1) begin
                c  = hist[i][(ec - LAT[i] - 1) % 16];
                cx = c % ht(i);
                cy = c / ht(i);
                act = (cx < HA[i]) && (cy < VA[i]);
                exp_pix[i] = act ? pin : 1'b0;
                exp_hs[i]  = (cx >= HA[i] + HF[i] && cx < HA[i] + HF[i] + HS[i]) ? POL[i] : !POL[i];
                exp_vs[i]  = (cy >= VA[i] + VF[i] && cy < VA[i] + VF[i] + VS[i]) ? POL[i] : !POL[i];
            end else begin
                exp_pix[i] = 1'b0;
                exp_hs[i]  = !POL[i];
                exp_vs[i]  = !POL[i];
            end
        end
    end

    // Game-pipeline stand-in: pixel for the coordinate issued LAT clocks ago
    always @(negedge clk) begin : pixel_drive
        int   c, cx, cy;
        logic act, v;
        for (int i = 0; i < 2; i++) begin
            c  = (ec >= LAT[i]) ? hist[i][(ec - LAT[i]) % 16] : 0;
            cx = c % ht(i);
            cy = c / ht(i);
            act = (cx < HA[i]) && (cy < VA[i]);
            case (pix_mode)
                1:       v = 1'(cx % 2);
                2:       v = 1'b1;
                default: v = (act || i == 0) ? 1'($urandom_range(0, 1)) : 1'bx;
            endcase
            if (i == 0) pixel_in = v;
            else        pixel_in_s = v;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({vga_pixel, vga_hsync, vga_vsync} !== 3'b000) begin
            bad++;
            $display("FAIL reset_pins actual=%b required=000", {vga_pixel, vga_hsync, vga_vsync});
        end
        total++;
        if ({vga_pixel_s, vga_hsync_s, vga_vsync_s} !== 3'b011) begin
            bad++;
            $display("FAIL reset_pins_small actual=%b required=011", {vga_pixel_s, vga_hsync_s, vga_vsync_s});
        end
        total++;
        if (x !== 11'd0 || y !== 10'd0 || x_s !== 11'd0 || y_s !== 10'd0) begin
            bad++;
            $display("FAIL reset_xy actual=%0d,%0d/%0d,%0d required=0,0/0,0", x, y, x_s, y_s);
        end
        total++;
        if ({active, frame_start, line_start} !== 3'b111) begin
            bad++;
            $display("FAIL reset_flags actual=%b required=111", {active, frame_start, line_start});
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (x !== 11'd5 || y !== 10'd0) begin
            bad++;
            $display("FAIL reset_release_x actual=%0d,%0d required=5,0", x, y);
        end
        $display("test_reset done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_line_timing();
        bit found = 1'b0;
        int rise = -1;
        int width = 0;
        int next_ls = -1;
        for (int k = 0; k < 1200 && !found; k++) begin
            @(negedge clk);
            if (line_start === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL line_start_wait actual=none required=pulse");
        end
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (vga_hsync === 1'b1) begin
                width++;
                if (rise < 0) rise = k;
            end
            if (line_start === 1'b1 && next_ls < 0) next_ls = k;
        end
        total++;
        if (rise != 843) begin
            bad++;
            $display("FAIL hsync_rise actual=%0d required=843", rise);
        end
        total++;
        if (width != 128) begin
            bad++;
            $display("FAIL hsync_width actual=%0d required=128", width);
        end
        total++;
        if (next_ls != 1056) begin
            bad++;
            $display("FAIL line_period actual=%0d required=1056", next_ls);
        end
        $display("test_line_timing rise=%0d width=%0d period=%0d", rise, width, next_ls);
    endtask

    task automatic test_random_model();
        int ex, ey, sx, sy;
        int drop = 0;
        logic [26:0] exp_d, exp_s;
        pix_mode = 0;
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            ex = idx[0] % ht(0);
            ey = idx[0] / ht(0);
            sx = idx[1] % ht(1);
            sy = idx[1] / ht(1);
            exp_d = {11'(ex), 10'(ey),
                     (enable === 1'b1) && ex < HA[0] && ey < VA[0],
                     (enable === 1'b1) && idx[0] == 0,
                     (enable === 1'b1) && ex == 0,
                     exp_pix[0], exp_hs[0], exp_vs[0]};
            exp_s = {11'(sx), 10'(sy),
                     (enable === 1'b1) && sx < HA[1] && sy < VA[1],
                     (enable === 1'b1) && idx[1] == 0,
                     (enable === 1'b1) && sx == 0,
                     exp_pix[1], exp_hs[1], exp_vs[1]};
            total++;
            if ({x, y, active, frame_start, line_start, vga_pixel, vga_hsync, vga_vsync} !== exp_d) begin
                bad++;
                $display("FAIL model_default cyc=%0d actual=%h required=%h", k,
                         {x, y, active, frame_start, line_start, vga_pixel, vga_hsync, vga_vsync}, exp_d);
            end
            total++;
            if ({x_s, y_s, active_s, frame_start_s, line_start_s, vga_pixel_s, vga_hsync_s, vga_vsync_s} !== exp_s) begin
                bad++;
                $display("FAIL model_small cyc=%0d actual=%h required=%h", k,
                         {x_s, y_s, active_s, frame_start_s, line_start_s, vga_pixel_s, vga_hsync_s, vga_vsync_s}, exp_s);
            end
            if (drop > 0) begin
                drop--;
                enable = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                drop = int'($urandom_range(0, 4));
                enable = 1'b0;
            end else begin
                enable = 1'b1;
            end
        end
        enable = 1'b1;
        $display("test_random_model done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_pixel_alignment();
        int errs = 0;
        logic want;
        pix_mode = 1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        for (int k = 0; k < 1056; k++) begin
            @(negedge clk);
            want = (k < 800) ? 1'(k % 2) : 1'b0;
            total++;
            if (vga_pixel !== want) begin
                bad++;
                errs++;
                $display("FAIL pixel_align pos=%0d actual=%b required=%b", k, vga_pixel, want);
            end
        end
        $display("test_pixel_alignment positions=1056 errors=%0d", errs);
    endtask

    task automatic test_blanking_mask();
        int ones = 0;
        int ones_s = 0;
        int clash = 0;
        pix_mode = 2;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        for (int k = 0; k < 1056; k++) begin
            @(negedge clk);
            if (vga_pixel === 1'b1) ones++;
            if (k >= 1 && k <= 560 && vga_pixel_s === 1'b1) ones_s++;
            if (vga_pixel_s === 1'b1 && vga_vsync_s === 1'b0) clash++;
        end
        total++;
        if (ones != 800) begin
            bad++;
            $display("FAIL blank_line_ones actual=%0d required=800", ones);
        end
        total++;
        if (ones_s != 200) begin
            bad++;
            $display("FAIL blank_frame_ones_small actual=%0d required=200", ones_s);
        end
        total++;
        if (clash != 0) begin
            bad++;
            $display("FAIL pixel_in_vsync actual=%0d required=0", clash);
        end
        pix_mode = 0;
        $display("test_blanking_mask ones=%0d ones_small=%0d", ones, ones_s);
    endtask

    task automatic test_frame_timing();
        int vs_rise = -1;
        int vs_len = 0;
        int next_fs = -1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (vga_vsync_s === 1'b0) begin
                vs_len++;
                if (vs_rise < 0) vs_rise = k;
            end
            if (frame_start_s === 1'b1 && next_fs < 0) next_fs = k;
        end
        total++;
        if (vs_rise != 389) begin
            bad++;
            $display("FAIL vsync_start actual=%0d required=389", vs_rise);
        end
        total++;
        if (vs_len != 70) begin
            bad++;
            $display("FAIL vsync_len actual=%0d required=70", vs_len);
        end
        total++;
        if (next_fs != 560) begin
            bad++;
            $display("FAIL frame_period actual=%0d required=560", next_fs);
        end
        $display("test_frame_timing vs_start=%0d vs_len=%0d period=%0d", vs_rise, vs_len, next_fs);
    endtask

    task automatic test_restart(input bit use_enable);
        bit found = 1'b0;
        int rise = -1;
        int rise_s = -1;
        logic [2:0] want_flags;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (idx[1] == 5 * ht(1) + 10) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL restart_wait actual=none required=x10y5");
        end
        if (use_enable) enable = 1'b0;
        else            reset_n = 1'b0;
        want_flags = use_enable ? 3'b000 : 3'b111;
        #1;
        if (use_enable) begin
            total++;
            if ({active, frame_start, line_start, active_s, frame_start_s, line_start_s} !== 6'b0) begin
                bad++;
                $display("FAIL disable_flags actual=%b required=000000",
                         {active, frame_start, line_start, active_s, frame_start_s, line_start_s});
            end
        end
        @(negedge clk);
        total++;
        if ({vga_pixel, vga_hsync, vga_vsync, vga_pixel_s, vga_hsync_s, vga_vsync_s} !== 6'b000011) begin
            bad++;
            $display("FAIL restart_idle use_enable=%0d actual=%b required=000011", use_enable,
                     {vga_pixel, vga_hsync, vga_vsync, vga_pixel_s, vga_hsync_s, vga_vsync_s});
        end
        total++;
        if (x !== 11'd0 || y !== 10'd0 || x_s !== 11'd0 || y_s !== 10'd0) begin
            bad++;
            $display("FAIL restart_xy actual=%0d,%0d/%0d,%0d required=0,0/0,0", x, y, x_s, y_s);
        end
        total++;
        if ({active, frame_start, line_start} !== want_flags) begin
            bad++;
            $display("FAIL restart_flags use_enable=%0d actual=%b required=%b", use_enable,
                     {active, frame_start, line_start}, want_flags);
        end
        repeat (9) @(negedge clk);
        enable  = 1'b1;
        reset_n = 1'b1;
        #1;
        total++;
        if ({frame_start, frame_start_s} !== 2'b11) begin
            bad++;
            $display("FAIL restart_frame_start actual=%b required=11", {frame_start, frame_start_s});
        end
        for (int k = 1; k <= 900; k++) begin
            @(negedge clk);
            if (rise < 0 && vga_hsync === 1'b1) rise = k;
            if (rise_s < 0 && vga_hsync_s === 1'b0) rise_s = k;
        end
        total++;
        if (rise != 843) begin
            bad++;
            $display("FAIL restart_hsync use_enable=%0d actual=%0d required=843", use_enable, rise);
        end
        total++;
        if (rise_s != 28) begin
            bad++;
            $display("FAIL restart_hsync_small use_enable=%0d actual=%0d required=28", use_enable, rise_s);
        end
        $display("test_restart use_enable=%0d hsync=%0d hsync_small=%0d", use_enable, rise, rise_s);
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_random_model();
        test_pixel_alignment();
        test_blanking_mask();
        test_frame_timing();
        test_restart(1'b1);
        test_restart(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case something stalls the sequence
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
